// File: rtl/inst_fetch.sv
// Instruction-fetch stage: reads one 32-bit instruction as four byte reads over
// a shared 8-bit synchronous port and hands it to decode with valid/ready.
module inst_fetch #(
    parameter int ADDR_W = 32,
    parameter int BYTES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    output logic              stall_req_o,
    input  logic              flush_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_a_o,
    input  logic [7:0]        mem_din_i,
    input  logic              mem_busy_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              id_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] last_addr_r;
    logic [2:0]        req_cnt_r;
    logic [2:0]        rcv_cnt_r;
    logic              pend_r;
    logic [23:0]       bytes_r;
    logic [31:0]       inst_r;
    logic [ADDR_W-1:0] inst_pc_r;
    logic              inst_valid_r;

    logic              stall_raw_s;
    logic              accept_s;
    logic              issue_s;
    logic              capture_s;
    logic              last_capture_s;
    logic [ADDR_W-1:0] issue_addr_s;

    // Handshake, request and capture qualifiers; flush overrides everything.
    always_comb begin
        stall_raw_s = 1'b1;
        case (state_r)
            ST_IDLE:  stall_raw_s = 1'b0;
            ST_VALID: stall_raw_s = ~id_ready_i;
            ST_FETCH: stall_raw_s = 1'b1;
            default:  stall_raw_s = 1'b1;
        endcase
        stall_req_o    = stall_raw_s & ~flush_i;
        accept_s       = ~stall_req_o & ce_i & ~flush_i;
        issue_s        = (state_r == ST_FETCH) && (req_cnt_r < 3'(BYTES))
                         && !mem_busy_i && !flush_i;
        capture_s      = (state_r == ST_FETCH) && pend_r && !flush_i;
        last_capture_s = capture_s && (rcv_cnt_r == 3'(BYTES - 1));
        issue_addr_s   = fetch_pc_r + ADDR_W'(req_cnt_r);
        mem_rd_o       = issue_s;
        mem_a_o        = issue_s ? issue_addr_s : last_addr_r;
    end

    // Next-state selection.
    always_comb begin
        next_state_s = state_r;
        if (flush_i) begin
            next_state_s = ST_IDLE;
        end else if (accept_s) begin
            next_state_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_IDLE:  next_state_s = ST_IDLE;
                ST_FETCH: next_state_s = last_capture_s ? ST_VALID : ST_FETCH;
                ST_VALID: next_state_s = id_ready_i ? ST_IDLE : ST_VALID;
                default:  next_state_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Fetch datapath: counters, byte shift register and output holding registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r   <= '0;
            last_addr_r  <= '0;
            req_cnt_r    <= 3'd0;
            rcv_cnt_r    <= 3'd0;
            pend_r       <= 1'b0;
            bytes_r      <= 24'h0;
            inst_r       <= 32'h0;
            inst_pc_r    <= '0;
            inst_valid_r <= 1'b0;
        end else begin
            pend_r <= issue_s;
            if (issue_s) begin
                req_cnt_r   <= req_cnt_r + 3'd1;
                last_addr_r <= issue_addr_s;
            end
            // Bytes arrive in address order, so shifting in from the top leaves {b2,b1,b0}.
            if (capture_s) begin
                bytes_r   <= {mem_din_i, bytes_r[23:8]};
                rcv_cnt_r <= rcv_cnt_r + 3'd1;
            end
            if (flush_i || accept_s) begin
                req_cnt_r <= 3'd0;
                rcv_cnt_r <= 3'd0;
            end
            if (accept_s) begin
                fetch_pc_r <= pc_i;
            end
            if (last_capture_s) begin
                inst_r    <= {mem_din_i, bytes_r};
                inst_pc_r <= fetch_pc_r;
            end
            if (flush_i) begin
                inst_valid_r <= 1'b0;
            end else if (last_capture_s) begin
                inst_valid_r <= 1'b1;
            end else if (state_r == ST_VALID && id_ready_i) begin
                inst_valid_r <= 1'b0;
            end
        end
    end

    assign inst_o       = inst_r;
    assign inst_pc_o    = inst_pc_r;
    assign inst_valid_o = inst_valid_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed and randomized fetches against a byte-memory
// reference that predicts strobe addresses, latency and assembled words.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = 32'h0;
    logic        ce_i = 1'b0;
    logic        stall_req_o;
    logic        flush_i = 1'b0;
    logic        mem_rd_o;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_din_i = 8'h0;
    logic        mem_busy_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        id_ready_i = 1'b0;

    logic [7:0]  mem [0:1023];
    int          n_tests = 0;
    int          n_fail  = 0;

    inst_fetch #(.ADDR_W(32), .BYTES(4)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .stall_req_o(stall_req_o),
        .flush_i(flush_i), .mem_rd_o(mem_rd_o), .mem_a_o(mem_a_o),
        .mem_din_i(mem_din_i), .mem_busy_i(mem_busy_i), .inst_o(inst_o),
        .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o), .id_ready_i(id_ready_i)
    );

    always #5 clk = ~clk;

    // Synchronous byte memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_o) mem_din_i <= mem[mem_a_o[9:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        logic [31:0] a;
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            a = pc + 32'(k);
            w[8*k +: 8] = mem[a[9:0]];
        end
        return w;
    endfunction

    // Accept pc in cycle 0, then follow the fetch until valid; stays in VALID afterwards.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] busy_mask, input int hold);
        int          req;
        int          done_c;
        bit          seen;
        bit          exp_rd;
        bit          exp_v;
        logic [31:0] a;
        @(negedge clk);
        pc_i = pc; ce_i = 1'b1; flush_i = 1'b0; id_ready_i = 1'b1; mem_busy_i = 1'b0;
        #1;
        check("accept_stall", 32'(stall_req_o), 32'h0);
        req = 0; done_c = -1; seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            ce_i = 1'b0; id_ready_i = 1'b0; pc_i = $urandom; mem_busy_i = busy_mask[c % 32];
            #1;
            exp_rd = (req < 4) && !mem_busy_i;
            check("mem_rd", 32'(mem_rd_o), 32'(exp_rd));
            if (exp_rd) begin
                a = pc + 32'(req);
                check("mem_a", mem_a_o, a);
                req++;
                if (req == 4) done_c = c;
            end else if (req > 0) begin
                a = pc + 32'(req - 1);
                check("mem_a_hold", mem_a_o, a);
            end
            exp_v = (done_c > 0) && (c >= done_c + 2);
            check("valid", 32'(inst_valid_o), 32'(exp_v));
            check("stall_fetch", 32'(stall_req_o), 32'h1);
            if (exp_v || inst_valid_o) seen = 1'b1;
        end
        mem_busy_i = 1'b0;
        check("valid_seen", 32'(inst_valid_o), 32'h1);
        check("inst", inst_o, exp_word(pc));
        check("inst_pc", inst_pc_o, pc);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            id_ready_i = 1'b0; ce_i = 1'($urandom_range(0, 1)); pc_i = $urandom;
            #1;
            check("hold_inst", inst_o, exp_word(pc));
            check("hold_valid", 32'(inst_valid_o), 32'h1);
            check("hold_stall", 32'(stall_req_o), 32'h1);
        end
    endtask

    // Consume the instruction without a new address and confirm the stage idles.
    task automatic drain();
        @(negedge clk);
        id_ready_i = 1'b1; ce_i = 1'b0; flush_i = 1'b0;
        #1;
        check("drain_stall", 32'(stall_req_o), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            id_ready_i = 1'b0;
            #1;
            check("idle_valid", 32'(inst_valid_o), 32'h0);
            check("idle_rd", 32'(mem_rd_o), 32'h0);
            check("idle_stall", 32'(stall_req_o), 32'h0);
        end
    endtask

    // Start a fetch and flush it in cycle fc, with ce_i held high to prove no accept.
    task automatic fetch_flush(input logic [31:0] pc, input int fc);
        @(negedge clk);
        pc_i = pc; ce_i = 1'b1; flush_i = 1'b0; id_ready_i = 1'b1; mem_busy_i = 1'b0;
        for (int c = 1; c < fc; c++) begin
            @(negedge clk);
            ce_i = 1'b0; id_ready_i = 1'b0;
        end
        @(negedge clk);
        flush_i = 1'b1; ce_i = 1'b1; pc_i = 32'h0000_0040;
        #1;
        check("flush_rd", 32'(mem_rd_o), 32'h0);
        check("flush_stall", 32'(stall_req_o), 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            flush_i = 1'b0; ce_i = 1'b0;
            #1;
            check("post_flush_valid", 32'(inst_valid_o), 32'h0);
            check("post_flush_rd", 32'(mem_rd_o), 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;

        #2 rst = 1'b0;
        #1;
        check("rst_inst", inst_o, 32'h0);
        check("rst_inst_pc", inst_pc_o, 32'h0);
        check("rst_valid", 32'(inst_valid_o), 32'h0);
        check("rst_rd", 32'(mem_rd_o), 32'h0);
        check("rst_a", mem_a_o, 32'h0);
        check("rst_stall", 32'(stall_req_o), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        fetch(32'h0, 32'h0, 0);
        check("directed_word", inst_o, 32'h0000_0513);
        fetch(32'h0, 32'h0000_0004, 3);
        fetch(32'h4, 32'h0, 0);
        fetch_flush(32'h80, 3);
        fetch(32'h100, 32'h0, 1);

        // Flush coincident with a VALID handshake voids it and does not accept.
        @(negedge clk);
        flush_i = 1'b1; id_ready_i = 1'b1; ce_i = 1'b1; pc_i = 32'h0000_0200;
        #1;
        check("vflush_stall", 32'(stall_req_o), 32'h0);
        @(negedge clk);
        flush_i = 1'b0; id_ready_i = 1'b0; ce_i = 1'b0;
        #1;
        check("vflush_valid", 32'(inst_valid_o), 32'h0);
        check("vflush_rd", 32'(mem_rd_o), 32'h0);

        fetch(32'hFFFF_FFFE, 32'h0, 0);
        drain();

        // Asynchronous reset in the middle of a fetch.
        @(negedge clk);
        pc_i = 32'h0000_0200; ce_i = 1'b1; id_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            ce_i = 1'b0; id_ready_i = 1'b0;
        end
        #1 rst = 1'b0;
        #1;
        check("mid_rst_inst", inst_o, 32'h0);
        check("mid_rst_pc", inst_pc_o, 32'h0);
        check("mid_rst_valid", 32'(inst_valid_o), 32'h0);
        check("mid_rst_rd", 32'(mem_rd_o), 32'h0);
        check("mid_rst_a", mem_a_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_rel_stall", 32'(stall_req_o), 32'h0);
        fetch(32'h0000_0300, 32'h0, 0);

        for (int r = 0; r < 8; r++) begin
            fetch($urandom, $urandom & $urandom, $urandom_range(0, 3));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
